memstore_arbiter: RTL and testbench
===================================

// Module: memstore_arbiter
// PURPOSE
//   Shares one __builtin_memstore write channel between N_REQ requester FSMs (IP wrappers storing results to memory).
//   Each requester presents data/addr/size with start_port held high until its done pulse. The arbiter grants one at a
//   time, drives the store unit, and routes its done_port back. Sits between wrapper FSMs and the single memstore instance.
// PARAMETERS
//   N_REQ          4   number of requesters, 2..8
//   BITSIZE_data   64  store data width
//   BITSIZE_addr   32  store address width
//   BITSIZE_size   7   store size field width (bits to write)
// PORTS
//   clock          in   1                  single clock, rising edge
//   reset          in   1                  asynchronous, active-low
//   req_start      in   N_REQ              per-requester start_port, held until its req_done
//   req_data       in   N_REQ*BITSIZE_data packed, requester i at [i*BITSIZE_data +: BITSIZE_data]
//   req_addr       in   N_REQ*BITSIZE_addr packed likewise
//   req_size       in   N_REQ*BITSIZE_size packed likewise
//   req_done       out  N_REQ              one-cycle done pulse to the granted requester
//   st_start_port  out  1                  start_port to memstore
//   st_data        out  BITSIZE_data       data to memstore
//   st_addr        out  BITSIZE_addr       addr to memstore
//   st_size        out  BITSIZE_size       size to memstore
//   st_done_port   in   1                  done_port from memstore
//   busy           out  1                  high while a grant is active
//   grant_id       out  3                  index of current/last granted requester
//   store_count    out  16                 completed stores, wraps 0xFFFF->0
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, grant_id=0, rr_ptr=0, store_count=0; req_done=0, st_start_port=0,
//     st_data/st_addr/st_size=0, busy=0. Reset mid-store aborts silently; no req_done is issued.
//   FSM states: IDLE, BUSY.
//   IDLE: if any req_start bit set, select winner, register grant_id, -> BUSY at next edge. Else stay.
//     Outputs: st_start_port=0, st_data/addr/size=0, busy=0, req_done=0.
//   BUSY: st_start_port=1, busy=1; st_data/addr/size combinationally muxed from requester grant_id (requester holds them stable).
//     When st_done_port=1: req_done[grant_id]=1 same cycle (combinational), store_count+=1, rr_ptr=(grant_id+1)%N_REQ, -> IDLE.
//     st_start_port drops the cycle after done, as the memstore protocol requires.
//   Latency: req_start rise -> st_start_port rise = 1 cycle; st_done_port -> req_done = 0 cycles.
//   Minimum 1 IDLE cycle between consecutive grants; back-to-back throughput = store latency + 1 cycle.
//   Requesters deassert req_start in the cycle after req_done, so a finished requester is never re-granted.
//   req_start dropping while granted (protocol violation): ignored; arbiter holds st_start_port until st_done_port.
//   st_done_port in IDLE: ignored, no req_done, store_count unchanged.
//   Winner selection (default, round-robin): first set req_start bit scanning from rr_ptr upward, wrapping N_REQ-1->0.
//   Width: grant_id zero-extended to 3 bits; rr_ptr wraps modulo N_REQ (non-power-of-2 N_REQ supported).
// CONFIGURATION
//   MEMSTORE_ARB_FIXED_PRIO_EN defined: fixed priority; lowest set req_start index wins; rr_ptr unused (held 0).
//   Undefined (default): round-robin as above; no requester starves while others continuously request.
// TESTING
//   T1 reset: reset=0 mid-BUSY -> st_start_port, busy, req_done 0 same cycle; store_count=0; state IDLE after release.
//   T2 single: req_start=4'b0100, data=64'hDEAD_BEEF_0000_0001, addr=32'h100, size=64; memstore done after 3 cycles ->
//     st_start_port high 1 cycle after start, st_addr=32'h100, req_done=4'b0100 on done cycle, store_count=1.
//   T3 round-robin: req_start=4'b1111 held by all, each drops after its done -> grant order 0,1,2,3; store_count=4.
//   T4 fairness: req0 re-asserts immediately after each done, req2 waiting -> order 0,2,0,...; req2 served within 2 grants.
//   T5 fixed prio (MEMSTORE_ARB_FIXED_PRIO_EN): req_start=4'b1010 -> grant 1 first, then 3; req1 re-request beats req3.
//   T6 wrap/spurious: preload 0xFFFF stores, one more -> store_count=0; st_done_port pulse in IDLE -> no req_done, count unchanged.

Source files
------------

// File: rtl/memstore_arbiter.sv
// Arbitrates N_REQ store requesters onto a single memstore write channel.
// Round-robin by default; define MEMSTORE_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module memstore_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BITSIZE_data = 64,
  parameter int BITSIZE_addr = 32,
  parameter int BITSIZE_size = 7
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req_start,
  input  logic [N_REQ*BITSIZE_data-1:0]   req_data,
  input  logic [N_REQ*BITSIZE_addr-1:0]   req_addr,
  input  logic [N_REQ*BITSIZE_size-1:0]   req_size,
  output logic [N_REQ-1:0]                req_done,
  output logic                            st_start_port,
  output logic [BITSIZE_data-1:0]         st_data,
  output logic [BITSIZE_addr-1:0]         st_addr,
  output logic [BITSIZE_size-1:0]         st_size,
  input  logic                            st_done_port,
  output logic                            busy,
  output logic [2:0]                      grant_id,
  output logic [15:0]                     store_count
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [2:0]        grant_q, grant_d, winner;
  logic [15:0]       count_q, count_d;
  logic [IW-1:0]     gsel;

  logic [N_REQ-1:0][BITSIZE_data-1:0] data_lane;
  logic [N_REQ-1:0][BITSIZE_addr-1:0] addr_lane;
  logic [N_REQ-1:0][BITSIZE_size-1:0] size_lane;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign data_lane[i] = req_data[i*BITSIZE_data +: BITSIZE_data];
    assign addr_lane[i] = req_addr[i*BITSIZE_addr +: BITSIZE_addr];
    assign size_lane[i] = req_size[i*BITSIZE_size +: BITSIZE_size];
  end

  assign gsel = grant_q[IW-1:0];

`ifdef MEMSTORE_ARB_FIXED_PRIO_EN
  // Downward scan so the lowest set index is the last (winning) assignment.
  always_comb begin
    winner = '0;
    for (int i = N_REQ-1; i >= 0; i--)
      if (req_start[i]) winner = 3'(i);
  end
`else
  logic [2:0] rr_ptr_q, rr_ptr_d;
  int         idx;

  // Scan offsets high-to-low so the smallest offset from rr_ptr wins.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (req_start[idx]) winner = 3'(idx);
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    count_d       = count_q;
`ifndef MEMSTORE_ARB_FIXED_PRIO_EN
    rr_ptr_d      = rr_ptr_q;
`endif
    req_done      = '0;
    st_start_port = 1'b0;
    st_data       = '0;
    st_addr       = '0;
    st_size       = '0;
    busy          = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_start) begin
          grant_d = winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        st_start_port = 1'b1;
        busy          = 1'b1;
        st_data       = data_lane[gsel];
        st_addr       = addr_lane[gsel];
        st_size       = size_lane[gsel];
        if (st_done_port) begin
          req_done[gsel] = 1'b1;
          count_d        = count_q + 16'd1;
`ifndef MEMSTORE_ARB_FIXED_PRIO_EN
          rr_ptr_d       = (int'(grant_q) + 1 == N_REQ) ? 3'd0 : grant_q + 3'd1;
`endif
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      count_q  <= '0;
`ifndef MEMSTORE_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      count_q  <= count_d;
`ifndef MEMSTORE_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign grant_id    = grant_q;
  assign store_count = count_q;

endmodule

// File: tb/tb_memstore_arbiter.sv
// Randomized self-checking bench for memstore_arbiter against a spec-level arbitration model.
module tb_memstore_arbiter;
  localparam int N = 4, DW = 64, AW = 32, SW = 7;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [N-1:0]           req_start;
  logic [N-1:0][DW-1:0]   rd;
  logic [N-1:0][AW-1:0]   ra;
  logic [N-1:0][SW-1:0]   rs;
  logic [N-1:0]           req_done;
  logic                   st_start_port;
  logic [DW-1:0]          st_data;
  logic [AW-1:0]          st_addr;
  logic [SW-1:0]          st_size;
  logic                   st_done_port;
  logic                   busy;
  logic [2:0]             grant_id;
  logic [15:0]            store_count;

  int checks = 0, errors = 0;
  int m_rr = 0, m_count = 0;

  always #5 clock = ~clock;

  memstore_arbiter #(.N_REQ(N), .BITSIZE_data(DW), .BITSIZE_addr(AW), .BITSIZE_size(SW)) dut (
    .clock(clock), .reset(reset), .req_start(req_start),
    .req_data(rd), .req_addr(ra), .req_size(rs), .req_done(req_done),
    .st_start_port(st_start_port), .st_data(st_data), .st_addr(st_addr), .st_size(st_size),
    .st_done_port(st_done_port), .busy(busy), .grant_id(grant_id), .store_count(store_count)
  );

  // Reference model: who should win given the pending set.
  function automatic int pick(input logic [N-1:0] m);
`ifdef MEMSTORE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (m[i]) return i;
`else
    for (int k = 0; k < N; k++) if (m[(m_rr + k) % N]) return (m_rr + k) % N;
`endif
    return -1;
  endfunction

  function automatic void retire(input int g);
    m_count = (m_count + 1) % 65536;
`ifdef MEMSTORE_ARB_FIXED_PRIO_EN
    m_rr = 0;
`else
    m_rr = (g + 1) % N;
`endif
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0 && g < N) v[g] = 1'b1;
    return v;
  endfunction

  task automatic randomize_lanes();
    for (int i = 0; i < N; i++) begin
      rd[i] = {$urandom, $urandom};
      ra[i] = $urandom;
      rs[i] = SW'($urandom_range(1, 64));
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; req_start = '0; st_done_port = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1; #1;
    m_rr = 0; m_count = 0;
  endtask

  // Memstore model: waits (bounded) for the grant, answers after lat cycles, then the requester drops.
  task automatic serve(input int lat, output int wait_n, output int gid, output logic [N-1:0] dn,
                       output logic [DW-1:0] d, output logic [AW-1:0] a, output logic [SW-1:0] s,
                       output logic b);
    wait_n = 0;
    while (st_start_port !== 1'b1 && wait_n < 20) begin
      @(negedge clock); #1; wait_n++;
    end
    gid = int'(grant_id); d = st_data; a = st_addr; s = st_size; b = busy;
    repeat (lat - 1) @(negedge clock);
    st_done_port = 1'b1; #1;
    dn = req_done;
    @(negedge clock);
    st_done_port = 1'b0;
    if (gid < N) req_start[gid] = 1'b0;
    #1;
  endtask

  int wn, g, e;
  logic [N-1:0] dn;
  logic [DW-1:0] d;
  logic [AW-1:0] a;
  logic [SW-1:0] s;
  logic b;

  task automatic test_reset();
    reset = 1'b0; req_start = '0; st_done_port = 1'b0; randomize_lanes();
    @(negedge clock); #1;
    checks++; if (store_count !== 16'h0) begin errors++; $display("FAIL rst_count got %h exp 0", store_count); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL rst_gid got %0d exp 0", grant_id); end
    checks++; if ({st_start_port, busy, req_done} !== '0) begin errors++; $display("FAIL rst_outs got %b exp 0", {st_start_port, busy, req_done}); end
    reset = 1'b1; req_start = 4'b0010;
    @(negedge clock); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before got %b exp 1", busy); end
    st_done_port = 1'b1; #1;
    reset = 1'b0; #1;
    checks++; if ({st_start_port, busy, req_done} !== '0) begin errors++; $display("FAIL rst_midbusy got %b exp 0", {st_start_port, busy, req_done}); end
    checks++; if (store_count !== 16'h0) begin errors++; $display("FAIL rst_mid_count got %h exp 0", store_count); end
    @(negedge clock);
    reset = 1'b1; st_done_port = 1'b0; req_start = '0;
    @(negedge clock); #1;
    checks++; if ({st_start_port, busy} !== 2'b00) begin errors++; $display("FAIL rst_idle got %b exp 00", {st_start_port, busy}); end
    m_rr = 0; m_count = 0;
  endtask

  task automatic test_single();
    rd[2] = 64'hDEAD_BEEF_0000_0001; ra[2] = 32'h100; rs[2] = 7'd64;
    req_start = 4'b0100; #1;
    checks++; if (st_start_port !== 1'b0) begin errors++; $display("FAIL single_no_early got %b exp 0", st_start_port); end
    e = pick(req_start);
    serve(3, wn, g, dn, d, a, s, b);
    retire(e);
    checks++; if (wn !== 1) begin errors++; $display("FAIL single_latency got %0d exp 1", wn); end
    checks++; if (g !== 2) begin errors++; $display("FAIL single_gid got %0d exp 2", g); end
    checks++; if (a !== 32'h100 || d !== 64'hDEAD_BEEF_0000_0001 || s !== 7'd64) begin errors++; $display("FAIL single_payload got %h/%h/%0d exp 100/deadbeef00000001/64", a, d, s); end
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", b); end
    checks++; if (dn !== 4'b0100) begin errors++; $display("FAIL single_done got %b exp 0100", dn); end
    checks++; if (store_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d exp 1", store_count); end
  endtask

  task automatic test_round_robin();
    do_reset(); randomize_lanes();
    req_start = 4'b1111;
    for (int k = 0; k < N; k++) begin
      e = pick(req_start);
      serve(int'($urandom_range(1, 4)), wn, g, dn, d, a, s, b);
      retire(e);
      checks++; if (g !== k || g !== e) begin errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", k, g, k); end
      checks++; if (dn !== onehot(e) || a !== ra[e]) begin errors++; $display("FAIL rr_done[%0d] got %b/%h exp %b/%h", k, dn, a, onehot(e), ra[e]); end
    end
    checks++; if (store_count !== 16'(m_count)) begin errors++; $display("FAIL rr_count got %0d exp %0d", store_count, m_count); end
  endtask

  task automatic test_fairness();
    int since2 = 0;
    req_start = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      e = pick(req_start);
      serve(int'($urandom_range(1, 3)), wn, g, dn, d, a, s, b);
      retire(e);
      checks++; if (g !== e) begin errors++; $display("FAIL fair_gid[%0d] got %0d exp %0d", k, g, e); end
      since2 = (g == 2) ? 0 : since2 + 1;
`ifndef MEMSTORE_ARB_FIXED_PRIO_EN
      checks++; if (since2 > 1) begin errors++; $display("FAIL fair_starve[%0d] got %0d exp <=1", k, since2); end
`endif
      req_start[0] = 1'b1; req_start[2] = 1'b1;
    end
    @(negedge clock); req_start = '0;
    e = pick(4'b0101); serve(1, wn, g, dn, d, a, s, b); retire(e);
    checks++; if (store_count !== 16'(m_count)) begin errors++; $display("FAIL fair_count got %0d exp %0d", store_count, m_count); end
  endtask

  task automatic test_priority();
    do_reset(); randomize_lanes();
    req_start = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      e = pick(req_start);
      serve(2, wn, g, dn, d, a, s, b);
      retire(e);
      checks++; if (g !== e || dn !== onehot(e)) begin errors++; $display("FAIL prio_gid[%0d] got %0d exp %0d", k, g, e); end
`ifdef MEMSTORE_ARB_FIXED_PRIO_EN
      checks++; if (k < 2 && g !== 1) begin errors++; $display("FAIL prio_fixed[%0d] got %0d exp 1", k, g); end
`endif
      if (k == 0) req_start[1] = 1'b1;
    end
    req_start = '0;
    @(negedge clock); #1;
  endtask

  task automatic test_wrap_spurious();
    req_start = '0; randomize_lanes();
    @(negedge clock); st_done_port = 1'b1; #1;
    checks++; if (req_done !== '0 || st_start_port !== 1'b0) begin errors++; $display("FAIL spur_done got %b/%b exp 0/0", req_done, st_start_port); end
    @(negedge clock); st_done_port = 1'b0; #1;
    checks++; if (store_count !== 16'(m_count)) begin errors++; $display("FAIL spur_count got %0d exp %0d", store_count, m_count); end
    force dut.count_q = 16'hFFFF;
    @(negedge clock);
    release dut.count_q;
    m_count = 16'hFFFF; #1;
    checks++; if (store_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %h exp ffff", store_count); end
    req_start = onehot(int'($urandom_range(0, N - 1)));
    e = pick(req_start);
    serve(2, wn, g, dn, d, a, s, b);
    retire(e);
    checks++; if (store_count !== 16'h0 || m_count != 0) begin errors++; $display("FAIL wrap_count got %h exp 0000", store_count); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      randomize_lanes();
      req_start = req_start | N'($urandom);
      if (req_start == '0) req_start = onehot(int'($urandom_range(0, N - 1)));
      e = pick(req_start);
      serve(int'($urandom_range(1, 5)), wn, g, dn, d, a, s, b);
      retire(e);
      checks++; if (wn > 19) begin errors++; $display("FAIL rnd_timeout[%0d] got %0d exp <20", k, wn); end
      checks++; if (g !== e) begin errors++; $display("FAIL rnd_gid[%0d] got %0d exp %0d", k, g, e); end
      checks++; if (e >= 0 && (d !== rd[e] || a !== ra[e] || s !== rs[e])) begin errors++; $display("FAIL rnd_payload[%0d] got %h/%h/%0d exp %h/%h/%0d", k, d, a, s, rd[e], ra[e], rs[e]); end
      checks++; if (dn !== onehot(e)) begin errors++; $display("FAIL rnd_done[%0d] got %b exp %b", k, dn, onehot(e)); end
      checks++; if (store_count !== 16'(m_count)) begin errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", k, store_count, m_count); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_start = '0; st_done_port = 1'b0;
    rd = '0; ra = '0; rs = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_priority();
    test_wrap_spurious();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
